// File: rtl/dmem_store_buffer_if.sv
// Core-side request/response and data-memory-side signals of the store buffer.
// The slave modport is the buffer's view; master is the environment's view.
interface dmem_store_buffer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sign_mask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sign_mask;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_stall;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_sign_mask, mem_rdata, mem_stall,
    output req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_sign_mask,
           mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_sign_mask, mem_rdata, mem_stall,
    input  req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_sign_mask,
           mem_read, mem_write
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-store FIFO and in-order request sequencer in front of a data memory that
// answers each one-cycle memread/memwrite pulse with a clk_stall high/low excursion.
module dmem_store_buffer #(
  parameter int unsigned StbDepth = 4,
  parameter int unsigned PtrW     = $clog2(StbDepth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  dmem_store_buffer_if.slave   bus_io,
  output logic [PtrW:0]        stb_count_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitHi, StWaitLo} state_e;

  localparam logic [PtrW:0] FullCnt = StbDepth[PtrW:0];

  state_e state_q, state_d;

  logic [31:0] fifo_addr_q  [StbDepth];
  logic [31:0] fifo_wdata_q [StbDepth];
  logic [3:0]  fifo_mask_q  [StbDepth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  logic        pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [3:0]  pend_mask_q, pend_mask_d;
  logic        is_load_q, is_load_d;

  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic fifo_empty, fifo_full, pop, push, load_acc, req_ready;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FullCnt);
  // Head leaves the FIFO only once the memory has finished the write.
  assign pop        = (state_q == StWaitLo) && !bus_io.mem_stall && !is_load_q;
  assign req_ready  = bus_io.req_write ? (!fifo_full || pop)
                                       : (fifo_empty && !pend_q && (state_q == StIdle));
  assign push       = bus_io.req_valid && req_ready && bus_io.req_write;
  assign load_acc   = bus_io.req_valid && req_ready && !bus_io.req_write;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pend_mask_d  = pend_mask_q;
    is_load_d    = is_load_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_mask_d   = mem_mask_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (load_acc) begin
      pend_d      = 1'b1;
      pend_addr_d = bus_io.req_addr;
      pend_mask_d = bus_io.req_sign_mask;
    end

    unique case (state_q)
      StIdle: begin
        if (!bus_io.mem_stall) begin
          if (!fifo_empty) begin
            mem_write_d = 1'b1;
            mem_addr_d  = fifo_addr_q[rd_ptr_q];
            mem_wdata_d = fifo_wdata_q[rd_ptr_q];
            mem_mask_d  = fifo_mask_q[rd_ptr_q];
            is_load_d   = 1'b0;
            state_d     = StIssue;
          end else if (pend_q) begin
            mem_read_d  = 1'b1;
            mem_addr_d  = pend_addr_q;
            mem_mask_d  = pend_mask_q;
            is_load_d   = 1'b1;
            pend_d      = 1'b0;
            state_d     = StIssue;
          end else if (load_acc) begin
            // Fast path: the load skips the pending slot.
            mem_read_d  = 1'b1;
            mem_addr_d  = bus_io.req_addr;
            mem_mask_d  = bus_io.req_sign_mask;
            is_load_d   = 1'b1;
            pend_d      = 1'b0;
            state_d     = StIssue;
          end
        end
      end
      StIssue:  state_d = StWaitHi;
      StWaitHi: if (bus_io.mem_stall) state_d = StWaitLo;
      StWaitLo: begin
        if (!bus_io.mem_stall) begin
          state_d = StIdle;
          if (is_load_q) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = bus_io.mem_rdata;
          end
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_mask_q  <= '0;
      is_load_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_mask_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_mask_q  <= pend_mask_d;
      is_load_q    <= is_load_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mask_q   <= mem_mask_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= bus_io.req_addr;
      fifo_wdata_q[wr_ptr_q] <= bus_io.req_wdata;
      fifo_mask_q[wr_ptr_q]  <= bus_io.req_sign_mask;
    end
  end

  assign bus_io.req_ready     = req_ready;
  assign bus_io.resp_valid    = resp_valid_q;
  assign bus_io.resp_rdata    = resp_rdata_q;
  assign bus_io.mem_addr      = mem_addr_q;
  assign bus_io.mem_wdata     = mem_wdata_q;
  assign bus_io.mem_sign_mask = mem_mask_q;
  assign bus_io.mem_read      = mem_read_q;
  assign bus_io.mem_write     = mem_write_q;
  assign stb_count_o          = count_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: stalling data-memory model, program-order scoreboard,
// table-driven vectors, hand-written corner sequences and a randomized phase.
module tb_dmem_store_buffer;
  localparam int Depth = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] stb_count;

  dmem_store_buffer_if bus ();

  dmem_store_buffer #(.StbDepth(4), .PtrW(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus_io      (bus),
    .stb_count_o (stb_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } op_t;

  // Data memory model: every pulse raises clk_stall for stall_len cycles.
  logic [31:0] mem_arr [logic [31:0]];
  int          stall_len = 2;
  int          stall_cnt = 0;
  logic [31:0] rdata_q = '0;
  logic        prev_stall = 1'b0;
  bit          wr_pending = 1'b0;
  int          done_writes = 0;
  int          n_wr = 0;

  assign bus.mem_stall = (stall_cnt != 0);
  assign bus.mem_rdata = rdata_q;

  initial forever begin
    @(posedge clk);
    if (wr_pending && stall_cnt == 0) begin
      done_writes++;
      wr_pending = 1'b0;
    end
    if (!rst_n) begin
      wr_pending  = 1'b0;
      done_writes = 0;
    end
    if (bus.mem_write) begin
      mem_arr[bus.mem_addr] = bus.mem_wdata;
      n_wr++;
      if (rst_n) wr_pending = 1'b1;
    end
    if (bus.mem_read)
      rdata_q <= mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : 32'h0;
    prev_stall <= (stall_cnt != 0);
    if (bus.mem_read || bus.mem_write) stall_cnt <= stall_len;
    else if (stall_cnt != 0)           stall_cnt <= stall_cnt - 1;
  end

  // Reference model: program-order op queue, load results from a word-level memory image.
  op_t         exp_ops [$];
  logic [31:0] exp_resp [$];
  logic [31:0] model_mem [logic [31:0]];
  int          acc_stores = 0;
  bit          load_out = 1'b0;
  int          cyc = 0;
  int          acc_times [$];
  bit          chk_en = 1'b0;
  op_t         mon_op;
  op_t         chk_op;
  logic        exp_rdy;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      acc_stores = 0;
      exp_ops.delete();
      exp_resp.delete();
      load_out = 1'b0;
    end else if (bus.req_valid && bus.req_ready) begin
      mon_op.wr    = bus.req_write;
      mon_op.addr  = bus.req_addr;
      mon_op.wdata = bus.req_wdata;
      mon_op.mask  = bus.req_sign_mask;
      exp_ops.push_back(mon_op);
      if (bus.req_write) begin
        acc_stores++;
        model_mem[bus.req_addr] = bus.req_wdata;
        acc_times.push_back(cyc);
      end else begin
        exp_resp.push_back(rd_model(bus.req_addr));
        load_out = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && chk_en) begin
      if (bus.resp_valid) begin
        if (exp_resp.size() == 0) chk("resp_unexpected", bus.resp_valid, 0);
        else                      chk("resp_rdata", bus.resp_rdata, exp_resp.pop_front());
        load_out = 1'b0;
      end
      if (bus.mem_read || bus.mem_write) begin
        chk("issue_while_stall", prev_stall, 0);
        if (exp_ops.size() == 0) begin
          chk("mem_unexpected", {bus.mem_read, bus.mem_write}, 0);
        end else begin
          chk_op = exp_ops.pop_front();
          chk("mem_dir", {bus.mem_read, bus.mem_write}, chk_op.wr ? 2'b01 : 2'b10);
          chk("mem_addr", bus.mem_addr, chk_op.addr);
          chk("mem_sign_mask", bus.mem_sign_mask, chk_op.mask);
          if (chk_op.wr) chk("mem_wdata", bus.mem_wdata, chk_op.wdata);
        end
      end
      chk("stb_count", stb_count, acc_stores - done_writes);
      if (bus.req_write)
        exp_rdy = ((acc_stores - done_writes) < Depth) || (wr_pending && stall_cnt == 0);
      else
        exp_rdy = (acc_stores == done_writes) && !load_out;
      chk("req_ready", bus.req_ready, exp_rdy);
    end
  end

  task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m);
    int w = 0;
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_write     = wr;
    bus.req_addr      = a;
    bus.req_wdata     = d;
    bus.req_sign_mask = m;
    #1;
    while (!bus.req_ready) begin
      @(negedge clk);
      #1;
      w++;
      if (w > 200) begin
        chk("req_timeout", bus.req_ready, 1);
        bus.req_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_quiet();
    int w = 0;
    idle(1);
    while ((acc_stores != done_writes) || load_out) begin
      @(negedge clk);
      w++;
      if (w > 500) begin
        chk("drain_timeout", acc_stores - done_writes + int'(load_out), 0);
        break;
      end
    end
    idle(1);
  endtask

  task automatic get_resp(output logic [31:0] d);
    d = 'x;
    idle(1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #3;
      if (bus.resp_valid) begin
        d = bus.resp_rdata;
        return;
      end
    end
    chk("resp_timeout", bus.resp_valid, 1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] got;
  int          lat;
  int          n0;

  initial begin
    bus.req_valid     = 1'b1;
    bus.req_write     = 1'b1;
    bus.req_addr      = 32'h1000;
    bus.req_wdata     = 32'h1111_2222;
    bus.req_sign_mask = 4'h2;
    mem_arr[32'h1004]   = 32'hDEAD_BEEF;
    model_mem[32'h1004] = 32'hDEAD_BEEF;

    tbl[0] = '{1'b1, 32'h1010, 32'h1234_5678, 4'h2, 32'h0};
    tbl[1] = '{1'b0, 32'h1010, 32'h0,         4'h2, 32'h1234_5678};
    tbl[2] = '{1'b1, 32'h1014, 32'h0000_00FF, 4'h0, 32'h0};
    tbl[3] = '{1'b1, 32'h1010, 32'hCAFE_F00D, 4'h1, 32'h0};
    tbl[4] = '{1'b0, 32'h1010, 32'h0,         4'h6, 32'hCAFE_F00D};
    tbl[5] = '{1'b0, 32'h1014, 32'h0,         4'h4, 32'h0000_00FF};
    tbl[6] = '{1'b0, 32'h1018, 32'h0,         4'h2, 32'h0};
    tbl[7] = '{1'b0, 32'h1004, 32'h0,         4'h2, 32'hDEAD_BEEF};

    // Reset held three cycles with a request present.
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("rst_mem_read", bus.mem_read, 0);
      chk("rst_mem_write", bus.mem_write, 0);
      chk("rst_stb_count", stb_count, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_rdata", bus.resp_rdata, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
    end
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    chk_en = 1'b1;

    // Fast-path load latency.
    stall_len = 2;
    send(1'b0, 32'h1004, 32'h0, 4'h2);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #3;
      if (bus.resp_valid) begin
        lat = k;
        break;
      end
    end
    chk("load_latency", lat, 4);
    chk("load_data", bus.resp_rdata, 32'hDEAD_BEEF);
    wait_quiet();

    // Single MMIO store.
    n0 = n_wr;
    send(1'b1, 32'h2000, 32'hA5, 4'h2);
    wait_quiet();
    chk("led_write_count", n_wr - n0, 1);
    chk("led_value", mem_arr[32'h2000], 32'hA5);

    // Five back-to-back stores; fifth rides the first pop.
    acc_times.delete();
    for (int i = 0; i < 5; i++) send(1'b1, 32'h1100 + 4 * i, 32'h1111_1111 * (i + 1), 4'hF);
    wait_quiet();
    if (acc_times.size() == 5) begin
      chk("b2b_gap1", acc_times[1] - acc_times[0], 1);
      chk("b2b_gap2", acc_times[2] - acc_times[1], 1);
      chk("b2b_gap3", acc_times[3] - acc_times[2], 1);
      chk("b2b_fifth", acc_times[4] - acc_times[0], 5);
    end else begin
      chk("b2b_accepts", acc_times.size(), 5);
    end
    chk("b2b_last_word", mem_arr[32'h1110], 32'h5555_5555);

    // Load behind a queued store to the same address.
    send(1'b1, 32'h1008, 32'h55, 4'h2);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h1008;
    #1 chk("load_blocked", bus.req_ready, 0);
    send(1'b0, 32'h1008, 32'h0, 4'h2);
    get_resp(got);
    chk("raw_load", got, 32'h55);
    wait_quiet();

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].mask);
      if (!tbl[i].wr) begin
        get_resp(got);
        chk($sformatf("tbl%0d_load", i), got, tbl[i].exp);
      end
    end
    wait_quiet();

    // Reset while the memory is still stalling an in-flight load.
    stall_len = 6;
    send(1'b0, 32'h1004, 32'h0, 4'h2);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst5_mem_read", bus.mem_read, 0);
    chk("rst5_mem_write", bus.mem_write, 0);
    chk("rst5_mem_addr", bus.mem_addr, 0);
    chk("rst5_mem_wdata", bus.mem_wdata, 0);
    chk("rst5_mem_mask", bus.mem_sign_mask, 0);
    chk("rst5_resp_valid", bus.resp_valid, 0);
    rst_n = 1'b1;
    stall_len = 2;
    send(1'b1, 32'h1020, 32'h0BAD_F00D, 4'hF);
    wait_quiet();
    chk("rst5_store", mem_arr[32'h1020], 32'h0BAD_F00D);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int w = 0;
      bit wr;
      logic [31:0] a;
      while (load_out && w < 200) begin
        @(negedge clk);
        bus.req_valid = 1'b0;
        w++;
      end
      stall_len = int'($urandom_range(1, 3));
      wr = ($urandom_range(0, 9) < 7);
      a  = ($urandom_range(0, 3) == 0) ? 32'h2000 : 32'h1000 + 4 * $urandom_range(0, 7);
      send(wr, a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    wait_quiet();
    chk("ops_left", exp_ops.size(), 0);
    chk("resp_left", exp_resp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
